// File: rtl/stream_pkg.sv
// Shared stream-arbitration definitions: mode encodings and a rotating-priority picker
// that other arbiters in this codebase can reuse.
package stream_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    localparam int   RR_MAX_CH  = 16;

    // Returns {found, index}: first set bit of valid scanning ptr, ptr+1, ... modulo nch.
    function automatic logic [4:0] rr_pick(input logic [15:0] valid,
                                           input logic [3:0]  ptr,
                                           input int          nch);
        logic [4:0] res;
        int         idx;
        res = '0;
        for (int k = 0; k < RR_MAX_CH; k++) begin
            idx = (int'(ptr) + k) % nch;
            if (k < nch && !res[4] && valid[idx]) begin
                res = {1'b1, idx[3:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: owns the rotating priority pointer, which moves past the
// granted channel only when the caller reports that the grant was consumed.
module rr_arbiter
    import stream_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  req,
    input  logic            advance,
    output logic [NCH-1:0]  grant_onehot,
    output logic [SELW-1:0] grant_idx,
    output logic            found
);

    logic [SELW-1:0] ptr_q, ptr_d;
    logic [15:0]     req_ext;
    logic [3:0]      ptr_ext;
    logic [4:0]      pick;

    always_comb begin
        req_ext            = '0;
        req_ext[NCH-1:0]   = req;
        ptr_ext            = '0;
        ptr_ext[SELW-1:0]  = ptr_q;
        pick               = rr_pick(req_ext, ptr_ext, NCH);
        found              = pick[4];
        grant_idx          = SELW'(pick[3:0]);
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_onehot
        assign grant_onehot[gi] = found && (grant_idx == SELW'(gi));
    end

    // Explicit wrap keeps the modulo correct when NCH is not a power of two.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer with valid/ready handshake, registered output stage,
// fixed-select or round-robin channel choice, and a source-channel tag per word.
module stream_mux_rr
    import stream_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;

    logic [NCH-1:0]   rr_onehot;
    logic [SELW-1:0]  rr_idx;
    logic             rr_found;
    logic             fixed_found;
    logic [SELW-1:0]  grant_idx;
    logic             grant_found;
    logic             load_en;
    logic             xfer;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (in_valid),
        .advance      (xfer && (mode == MODE_RR)),
        .grant_onehot (rr_onehot),
        .grant_idx    (rr_idx),
        .found        (rr_found)
    );

    // A select beyond the last channel never matches, so it simply yields no grant.
    always_comb begin
        fixed_found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
                fixed_found = 1'b1;
            end
        end
        if (mode == MODE_RR) begin
            grant_found = rr_found && (rr_onehot != '0);
            grant_idx   = rr_idx;
        end else begin
            grant_found = fixed_found;
            grant_idx   = sel;
        end
        load_en = !out_valid_q || out_ready;
        xfer    = rst_n && load_en && grant_found;
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
        assign in_ready[gi] = xfer && (grant_idx == SELW'(gi));
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (load_en) begin
            out_valid_d = grant_found;
            if (grant_found) begin
                out_data_d = in_data[grant_idx*WIDTH +: WIDTH];
                out_chan_d = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance for the main scenarios and a
// 3-channel instance for out-of-range select and non-power-of-two wrap.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        mode_a, out_ready_a, out_valid_a;
    logic [1:0]  sel_a, out_chan_a;
    logic [63:0] in_data_a;
    logic [3:0]  in_valid_a, in_ready_a;
    logic [15:0] out_data_a;

    logic        mode_b, out_ready_b, out_valid_b;
    logic [1:0]  sel_b, out_chan_b;
    logic [47:0] in_data_b;
    logic [2:0]  in_valid_b, in_ready_b;
    logic [15:0] out_data_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(16), .NCH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode_a), .sel(sel_a),
        .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_chan(out_chan_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a)
    );

    stream_mux_rr #(.WIDTH(16), .NCH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode_b), .sel(sel_b),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_chan(out_chan_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("[%0t] %s ok obs=%0h", $time, tag, obs);
        end else begin
            $display("[%0t] FAIL %s obs=%0h exp=%0h", $time, tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        mode_a      = 1'b1;
        sel_a       = 2'd0;
        in_data_a   = '0;
        in_valid_a  = 4'hF;
        out_ready_a = 1'b0;
        mode_b      = 1'b0;
        sel_b       = 2'd0;
        in_data_b   = '0;
        in_valid_b  = 3'b000;
        out_ready_b = 1'b0;

        // Reset state
        #3;
        chk("rst_valid", 32'(out_valid_a), 32'd0);
        chk("rst_data",  32'(out_data_a),  32'd0);
        chk("rst_chan",  32'(out_chan_a),  32'd0);
        chk("rst_ready", 32'(in_ready_a),  32'h0);
        in_valid_a = 4'h0;
        #20 rst_n = 1'b1;
        step();

        // Fixed select, channel 2
        in_data_a   = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
        mode_a      = 1'b0;
        sel_a       = 2'd2;
        in_valid_a  = 4'hF;
        out_ready_a = 1'b1;
        #1;
        chk("fix_ready0", 32'(in_ready_a), 32'h4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fix_data",  32'(out_data_a),  32'h000C);
            chk("fix_chan",  32'(out_chan_a),  32'd2);
            chk("fix_valid", 32'(out_valid_a), 32'd1);
            chk("fix_ready", 32'(in_ready_a),  32'h4);
        end

        // Round-robin fairness, pointer still 0
        mode_a = 1'b1;
        #1;
        chk("rr_ready0", 32'(in_ready_a), 32'h1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_chan",  32'(out_chan_a),  32'(i % 4));
            chk("rr_data",  32'(out_data_a),  32'hA + 32'(i % 4));
            chk("rr_valid", 32'(out_valid_a), 32'd1);
        end

        // Backpressure holding 0x00B0 from channel 1 (ptr becomes 2)
        in_data_a  = {16'h00D0, 16'h00C0, 16'h00B0, 16'h00A0};
        in_valid_a = 4'b0010;
        step();
        chk("bp_load", 32'(out_data_a), 32'h00B0);
        out_ready_a = 1'b0;
        in_valid_a  = 4'hF;
        #1;
        chk("bp_ready0", 32'(in_ready_a), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_data",  32'(out_data_a),  32'h00B0);
            chk("bp_chan",  32'(out_chan_a),  32'd1);
            chk("bp_valid", 32'(out_valid_a), 32'd1);
            chk("bp_ready", 32'(in_ready_a),  32'h0);
        end
        out_ready_a = 1'b1;
        #1;
        chk("bp_resume_ready", 32'(in_ready_a), 32'h4);
        step();
        chk("bp_resume_chan", 32'(out_chan_a), 32'd2);
        chk("bp_resume_data", 32'(out_data_a), 32'h00C0);

        // Sparse requests with wrap, ptr is 3
        in_valid_a = 4'b0010;
        #1;
        chk("sp_ready1", 32'(in_ready_a), 32'h2);
        step();
        chk("sp_chan1", 32'(out_chan_a), 32'd1);
        in_valid_a = 4'b1001;
        #1;
        chk("sp_ready3", 32'(in_ready_a), 32'h8);
        step();
        chk("sp_chan3", 32'(out_chan_a), 32'd3);
        chk("sp_data3", 32'(out_data_a), 32'h00D0);
        in_valid_a = 4'hF;
        #1;
        chk("sp_wrap_ready", 32'(in_ready_a), 32'h1);
        step();
        chk("sp_wrap_chan", 32'(out_chan_a), 32'd0);

        // Drain with no requests
        in_valid_a = 4'h0;
        step();
        chk("drain_valid", 32'(out_valid_a), 32'd0);

        // Reset mid-stream while holding 0x1234 (ptr is 1 beforehand)
        in_data_a  = {16'h00D0, 16'h00C0, 16'h1234, 16'h00A0};
        in_data_a[47:32] = 16'h1234;
        in_data_a[31:16] = 16'h00B0;
        mode_a     = 1'b0;
        sel_a      = 2'd2;
        in_valid_a = 4'b0100;
        step();
        chk("mid_load", 32'(out_data_a), 32'h1234);
        out_ready_a = 1'b0;
        in_valid_a  = 4'h0;
        step();
        chk("mid_hold", 32'(out_data_a), 32'h1234);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid_a), 32'd0);
        chk("mid_rst_data",  32'(out_data_a),  32'd0);
        chk("mid_rst_chan",  32'(out_chan_a),  32'd0);
        mode_a     = 1'b1;
        in_valid_a = 4'hF;
        #1;
        chk("mid_rst_ready", 32'(in_ready_a), 32'h0);
        #2 rst_n = 1'b1;
        out_ready_a = 1'b1;
        #1;
        chk("mid_post_ready", 32'(in_ready_a), 32'h1);
        step();
        chk("mid_post_chan", 32'(out_chan_a), 32'd0);
        chk("mid_post_data", 32'(out_data_a), 32'h00A0);

        // Three-channel build: out-of-range select, drain, RR wrap modulo 3
        in_data_b   = {16'h0122, 16'h0111, 16'h0100};
        mode_b      = 1'b0;
        sel_b       = 2'd1;
        in_valid_b  = 3'b111;
        out_ready_b = 1'b1;
        step();
        chk("b_load_chan",  32'(out_chan_b),  32'd1);
        chk("b_load_data",  32'(out_data_b),  32'h0111);
        sel_b = 2'd3;
        #1;
        chk("b_oor_ready", 32'(in_ready_b), 32'h0);
        step();
        chk("b_oor_valid", 32'(out_valid_b), 32'd0);
        chk("b_oor_ready2", 32'(in_ready_b), 32'h0);
        mode_b = 1'b1;
        #1;
        chk("b_rr_ready0", 32'(in_ready_b), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b_rr_chan", 32'(out_chan_b), 32'(i % 3));
            chk("b_rr_data", 32'(out_data_b), 32'h0100 + 32'h11 * 32'(i % 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
